// File: rtl/palette_if.sv
// Pixel, palette-write and commit signals between a pixel source/CPU (master)
// and the palette mapper (slave).
interface palette_if #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
);
  logic                  pix_valid_i;
  logic [IDX_W-1:0]      color_i;
  logic                  frame_start_i;
  logic                  wr_en_i;
  logic [IDX_W-1:0]      wr_addr_i;
  logic [3*CH_W-1:0]     wr_data_i;
  logic                  commit_i;
  logic [CH_W-1:0]       r_o;
  logic [CH_W-1:0]       g_o;
  logic [CH_W-1:0]       b_o;
  logic                  pix_valid_o;
  logic                  commit_pending_o;

  modport master (
    output pix_valid_i, color_i, frame_start_i, wr_en_i, wr_addr_i, wr_data_i, commit_i,
    input  r_o, g_o, b_o, pix_valid_o, commit_pending_o
  );

  modport slave (
    input  pix_valid_i, color_i, frame_start_i, wr_en_i, wr_addr_i, wr_data_i, commit_i,
    output r_o, g_o, b_o, pix_valid_o, commit_pending_o
  );
endinterface

// File: rtl/palette_mapper.sv
// Double-buffered colour palette lookup: CPU writes a shadow bank, which is
// copied into the active lookup bank on a frame boundary after a commit.
module palette_mapper #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  palette_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int PW    = 3 * CH_W;

  logic [PW-1:0]    shadow_q [DEPTH];
  logic [PW-1:0]    active_q [DEPTH];
  logic             commit_pending_q, commit_pending_d;
  logic             copy;
  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_color_q;
  logic             pix_valid_q;
  logic [PW-1:0]    rgb_q;

  assign copy = bus.frame_start_i & commit_pending_q;

  // A commit arriving on the copying edge re-arms for the following frame.
  always_comb begin
    commit_pending_d = commit_pending_q | bus.commit_i;
    if (copy) begin
      commit_pending_d = bus.commit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (bus.wr_en_i) begin
      shadow_q[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  // Non-blocking copy picks up the pre-write shadow on a simultaneous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        active_q[i] <= '0;
      end
    end else if (copy) begin
      for (int i = 0; i < DEPTH; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending_q <= 1'b0;
      s1_valid_q       <= 1'b0;
      s1_color_q       <= '0;
      pix_valid_q      <= 1'b0;
      rgb_q            <= '0;
    end else begin
      commit_pending_q <= commit_pending_d;
      s1_valid_q       <= bus.pix_valid_i;
      s1_color_q       <= bus.color_i;
      pix_valid_q      <= s1_valid_q;
      if (s1_valid_q) begin
        rgb_q <= active_q[s1_color_q];
      end
    end
  end

  assign bus.r_o              = rgb_q[PW-1 -: CH_W];
  assign bus.g_o              = rgb_q[2*CH_W-1 -: CH_W];
  assign bus.b_o              = rgb_q[CH_W-1:0];
  assign bus.pix_valid_o      = pix_valid_q;
  assign bus.commit_pending_o = commit_pending_q;
endmodule

// File: tb/tb_palette_mapper.sv
// Directed table-driven bench for palette_mapper plus a hand-written
// asynchronous reset sequence.
module tb_palette_mapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  palette_if #(.IDX_W(3), .CH_W(8)) bus ();

  palette_mapper #(.IDX_W(3), .CH_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [23:0] wd;
    logic        cm;
    logic        fs;
    logic        pv;
    logic [2:0]  col;
    logic        e_pv;
    logic [23:0] e_rgb;
    logic        e_cp;
  } vec_t;

  vec_t vecs [40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [23:0] wd,
                       input logic cm, input logic fs, input logic pv, input logic [2:0] col);
    bus.wr_en_i       = we;
    bus.wr_addr_i     = wa;
    bus.wr_data_i     = wd;
    bus.commit_i      = cm;
    bus.frame_start_i = fs;
    bus.pix_valid_i   = pv;
    bus.color_i       = col;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic e_pv, input logic [23:0] e_rgb, input logic e_cp);
    check({tag, ".pix_valid"}, 32'(bus.pix_valid_o), 32'(e_pv));
    check({tag, ".rgb"}, 32'({bus.r_o, bus.g_o, bus.b_o}), 32'(e_rgb));
    check({tag, ".commit_pending"}, 32'(bus.commit_pending_o), 32'(e_cp));
  endtask

  initial begin
    //          we    wa    wd          cm    fs    pv    col   e_pv  e_rgb       e_cp
    vecs[0]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 24'h000000, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h000000, 1'b0};
    vecs[2]  = '{1'b1, 3'd3, 24'hFF8040, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 24'h000000, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'hFF8040, 1'b0};
    vecs[7]  = '{1'b1, 3'd3, 24'h112233, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'hFF8040, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'hFF8040, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 24'hFF8040, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'hFF8040, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 24'hAABBCC, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'hFF8040, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'hFF8040, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 24'hFF8040, 1'b1};
    vecs[14] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 24'h000000, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'hAABBCC, 1'b0};
    vecs[16] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'hAABBCC, 1'b0};
    vecs[17] = '{1'b1, 3'd1, 24'h123456, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'hAABBCC, 1'b1};
    vecs[18] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'hAABBCC, 1'b0};
    vecs[19] = '{1'b1, 3'd1, 24'h654321, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'hAABBCC, 1'b1};
    vecs[20] = '{1'b1, 3'd1, 24'h0000FF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'hAABBCC, 1'b0};
    vecs[21] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'hAABBCC, 1'b0};
    vecs[22] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h654321, 1'b0};
    vecs[23] = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 24'h654321, 1'b1};
    vecs[24] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h654321, 1'b0};
    vecs[25] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'h654321, 1'b0};
    vecs[26] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h0000FF, 1'b0};
    vecs[27] = '{1'b1, 3'd4, 24'h445566, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h0000FF, 1'b0};
    vecs[28] = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0000FF, 1'b1};
    vecs[29] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 24'h0000FF, 1'b1};
    vecs[30] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h000000, 1'b1};
    vecs[31] = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 24'h000000, 1'b1};
    vecs[32] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 24'h000000, 1'b1};
    vecs[33] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h445566, 1'b1};
    vecs[34] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h445566, 1'b0};
    vecs[35] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 24'h445566, 1'b0};
    vecs[36] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 24'h0000FF, 1'b0};
    vecs[37] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 24'h112233, 1'b0};
    vecs[38] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h445566, 1'b0};
    vecs[39] = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 24'h445566, 1'b0};

    drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 24'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cm, vecs[i].fs, vecs[i].pv, vecs[i].col);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_pv, vecs[i].e_rgb, vecs[i].e_cp);
      $display("vec %0d: pv=%b col=%0d fs=%b cm=%b we=%b -> pv_o=%b rgb=%06h cp=%b", i,
               vecs[i].pv, vecs[i].col, vecs[i].fs, vecs[i].cm, vecs[i].we,
               bus.pix_valid_o, {bus.r_o, bus.g_o, bus.b_o}, bus.commit_pending_o);
    end

    // Arm a commit and put a pixel in flight, then reset mid-cycle.
    drive(1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b1, 3'd3);
    step();
    drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 1'b0, 24'h0, 1'b0);
    $display("async reset: pv_o=%b rgb=%06h cp=%b", bus.pix_valid_o, {bus.r_o, bus.g_o, bus.b_o},
             bus.commit_pending_o);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_outs($sformatf("post_rst%0d", i), 1'b0, 24'h0, 1'b0);
    end

    // Active bank must be all zero after reset.
    for (int i = 0; i <= 8; i++) begin
      drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b0, (i < 8), 3'(i));
      step();
      if (i >= 1) check_outs($sformatf("active_zero%0d", i - 1), 1'b1, 24'h0, 1'b0);
    end

    // Shadow bank must be all zero too: commit it and read back written entries.
    drive(1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b1, 1'b0, 3'd0);
    step();
    check_outs("shadow_copy", 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] idx;
      idx = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : (i == 2) ? 3'd3 : 3'd4;
      drive(1'b0, 3'd0, 24'h0, 1'b0, 1'b0, (i < 3), idx);
      step();
      if (i >= 1) check_outs($sformatf("shadow_zero%0d", i), 1'b1, 24'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
